// File: rtl/register_bank_sb_pkg.sv
// Shared CPU register-bank definitions: default widths, the hardwired-zero
// register index and the address type. Imported by the bank, its interface
// and its scoreboard.
package register_bank_sb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;

  // Entry 0 is never stored and never pending; it always reads as zero.
  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/register_bank_sb_if.sv
// Register-bank port bundle: writeback, issue-reserve and two read ports.
// master = decode/writeback side (drives strobes/addresses, receives data/busy).
// slave  = the register bank.
interface register_bank_sb_if
  import register_bank_sb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_value;
  logic                  reserve_enable;
  logic [ADDR_WIDTH-1:0] reserve_address;
  logic [ADDR_WIDTH-1:0] read_address1;
  logic [ADDR_WIDTH-1:0] read_address2;
  logic [DATA_WIDTH-1:0] value1;
  logic [DATA_WIDTH-1:0] value2;
  logic                  busy1;
  logic                  busy2;
  logic [ADDR_WIDTH:0]   pending_count;

  modport master (
    output write_enable, write_address, write_value,
    output reserve_enable, reserve_address,
    output read_address1, read_address2,
    input  value1, value2, busy1, busy2, pending_count
  );

  modport slave (
    input  write_enable, write_address, write_value,
    input  reserve_enable, reserve_address,
    input  read_address1, read_address2,
    output value1, value2, busy1, busy2, pending_count
  );

endinterface

// File: rtl/register_bank_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at writeback.
// Ports: write/reserve strobes+addresses, two read addresses -> busy1/busy2 (comb),
// pending_count (registered popcount, maintained incrementally, never wraps).
module register_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic                  reserve_enable,
  input  logic [ADDR_WIDTH-1:0] reserve_address,
  input  logic [ADDR_WIDTH-1:0] read_address1,
  input  logic [ADDR_WIDTH-1:0] read_address2,
  output logic                  busy1,
  output logic                  busy2,
  output logic [ADDR_WIDTH:0]   pending_count
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int CW       = ADDR_WIDTH + 1;

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CW-1:0]       count_q, count_d;
  logic                wr_hit, rsv_hit, set_new, clr_old;

  always_comb begin
    wr_hit  = write_enable && (write_address != '0);
    rsv_hit = reserve_enable && (reserve_address != '0);
    // A reserve on the same edge as a writeback to the same register wins:
    // the bit stays set, so no clear is counted for that register.
    set_new = rsv_hit && !pending_q[reserve_address];
    clr_old = wr_hit && pending_q[write_address] &&
              !(rsv_hit && (reserve_address == write_address));

    pending_d = pending_q;
    if (wr_hit)  pending_d[write_address]   = 1'b0;
    if (rsv_hit) pending_d[reserve_address] = 1'b1;

    count_d = count_q + CW'(set_new) - CW'(clr_old);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  // A writeback landing this cycle satisfies the reader when forwarding is on.
  always_comb begin
    busy1 = pending_q[read_address1] &&
            !((BYPASS != 0) && write_enable && (write_address == read_address1));
    busy2 = pending_q[read_address2] &&
            !((BYPASS != 0) && write_enable && (write_address == read_address2));
  end

  assign pending_count = count_q;

endmodule

// File: rtl/register_bank_sb.sv
// Register bank: 2**ADDR_WIDTH x DATA_WIDTH file, entry 0 hardwired zero, two
// combinational read ports, one synchronous write port, optional write-to-read
// bypass and a pending-write scoreboard (busy1/busy2, pending_count).
// Ports: clk, reset_n (async active-low), bus (register_bank_sb_if.slave).
module register_bank_sb
  import register_bank_sb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BYPASS     = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  register_bank_sb_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Entry 0 is held at zero by reset and never written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (bus.write_enable && (bus.write_address != '0)) begin
      regs[bus.write_address] <= bus.write_value;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  we,
    input logic [ADDR_WIDTH-1:0] wa,
    input logic [DATA_WIDTH-1:0] wv
  );
    if (addr == '0)                             return '0;
    if ((BYPASS != 0) && we && (wa == addr))    return wv;
    return stored;
  endfunction

  always_comb begin
    bus.value1 = read_port(bus.read_address1, regs[bus.read_address1],
                           bus.write_enable, bus.write_address, bus.write_value);
    bus.value2 = read_port(bus.read_address2, regs[bus.read_address2],
                           bus.write_enable, bus.write_address, bus.write_value);
  end

  register_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS)
  ) u_scoreboard (
    .clk             (clk),
    .reset_n         (reset_n),
    .write_enable    (bus.write_enable),
    .write_address   (bus.write_address),
    .reserve_enable  (bus.reserve_enable),
    .reserve_address (bus.reserve_address),
    .read_address1   (bus.read_address1),
    .read_address2   (bus.read_address2),
    .busy1           (bus.busy1),
    .busy2           (bus.busy2),
    .pending_count   (bus.pending_count)
  );

endmodule

// File: tb/tb_register_bank_sb.sv
// Directed bench for register_bank_sb: one bypassing and one non-bypassing
// instance driven with identical stimulus; outputs sampled mid-cycle.
module tb_register_bank_sb;
  import register_bank_sb_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  register_bank_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_b ();
  register_bank_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_n ();

  register_bank_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  register_bank_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut_n (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic we, input reg_addr_t wa, input logic [31:0] wv,
                        input logic re, input reg_addr_t rsa,
                        input reg_addr_t ra1, input reg_addr_t ra2);
    bus_b.write_enable    = we;  bus_n.write_enable    = we;
    bus_b.write_address   = wa;  bus_n.write_address   = wa;
    bus_b.write_value     = wv;  bus_n.write_value     = wv;
    bus_b.reserve_enable  = re;  bus_n.reserve_enable  = re;
    bus_b.reserve_address = rsa; bus_n.reserve_address = rsa;
    bus_b.read_address1   = ra1; bus_n.read_address1   = ra1;
    bus_b.read_address2   = ra2; bus_n.read_address2   = ra2;
  endtask

  initial begin
    reg_addr_t a;
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    set_in(1'b0, REG_ZERO, 32'h0, 1'b0, REG_ZERO, REG_ZERO, REG_ZERO);
    #12;

    // Reset state on every address
    for (int i = 0; i < 32; i++) begin
      a = reg_addr_t'(i);
      set_in(1'b0, REG_ZERO, 32'h0, 1'b0, REG_ZERO, a, ~a);
      #1;
      chk("rst_value1", bus_b.value1, 0);
      chk("rst_busy1",  bus_b.busy1,  0);
      chk("rst_value2", bus_b.value2, 0);
      chk("rst_n_value1", bus_n.value1, 0);
    end
    chk("rst_count", bus_b.pending_count, 0);

    @(negedge clk);
    reset_n = 1'b1;

    // Write x5, read next cycle
    @(negedge clk);
    set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, REG_ZERO, REG_ZERO, REG_ZERO);
    @(negedge clk);
    set_in(1'b0, REG_ZERO, 32'h0, 1'b0, REG_ZERO, 5'd5, 5'd5);
    #1;
    chk("x5_value1", bus_b.value1, 32'hDEADBEEF);
    chk("x5_n_value2", bus_n.value2, 32'hDEADBEEF);
    chk("x5_count", bus_b.pending_count, 0);

    // Write and reserve x0 are ignored
    @(negedge clk);
    set_in(1'b1, REG_ZERO, 32'hFFFFFFFF, 1'b1, REG_ZERO, REG_ZERO, REG_ZERO);
    #1;
    chk("x0_comb_value1", bus_b.value1, 0);
    chk("x0_comb_busy1",  bus_b.busy1,  0);
    @(posedge clk); #1;
    chk("x0_value1", bus_b.value1, 0);
    chk("x0_busy1",  bus_b.busy1,  0);
    chk("x0_count",  bus_b.pending_count, 0);
    chk("x0_n_value1", bus_n.value1, 0);

    // Bypass: x7 visible before the edge only with forwarding
    @(negedge clk);
    set_in(1'b1, 5'd7, 32'h12345678, 1'b0, REG_ZERO, 5'd7, REG_ZERO);
    #1;
    chk("byp_value1", bus_b.value1, 32'h12345678);
    chk("nobyp_value1_pre", bus_n.value1, 0);
    @(posedge clk); #1;
    chk("nobyp_value1_post", bus_n.value1, 32'h12345678);

    // Reserve x3, writeback x3
    @(negedge clk);
    set_in(1'b0, REG_ZERO, 32'h0, 1'b1, 5'd3, 5'd3, REG_ZERO);
    #1;
    chk("rsv3_busy_pre", bus_b.busy1, 0);
    @(posedge clk); #1;
    chk("rsv3_busy1", bus_b.busy1, 1);
    chk("rsv3_count", bus_b.pending_count, 1);
    @(negedge clk);
    set_in(1'b1, 5'd3, 32'hA5, 1'b0, REG_ZERO, 5'd3, REG_ZERO);
    #1;
    chk("wb3_busy1", bus_b.busy1, 0);
    chk("wb3_value1", bus_b.value1, 32'hA5);
    chk("wb3_n_busy1", bus_n.busy1, 1);
    chk("wb3_count_pre", bus_b.pending_count, 1);
    @(posedge clk); #1;
    chk("wb3_count", bus_b.pending_count, 0);
    chk("wb3_n_busy1_post", bus_n.busy1, 0);

    // x9 pending; same-edge write+reserve x9 keeps it pending
    @(negedge clk);
    set_in(1'b0, REG_ZERO, 32'h0, 1'b1, 5'd9, 5'd9, REG_ZERO);
    @(posedge clk); #1;
    chk("rsv9_count", bus_b.pending_count, 1);
    @(negedge clk);
    set_in(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd9, REG_ZERO);
    #1;
    chk("wr_rsv9_busy_b", bus_b.busy1, 0);
    chk("wr_rsv9_busy_n", bus_n.busy1, 1);
    @(negedge clk);
    set_in(1'b0, REG_ZERO, 32'h0, 1'b0, REG_ZERO, 5'd9, REG_ZERO);
    #1;
    chk("wr_rsv9_busy_post", bus_b.busy1, 1);
    chk("wr_rsv9_value", bus_b.value1, 32'h99);
    chk("wr_rsv9_count", bus_b.pending_count, 1);

    // Reserve x4 while writing back pending x9: net count unchanged
    @(negedge clk);
    set_in(1'b1, 5'd9, 32'h77, 1'b1, 5'd4, 5'd4, 5'd9);
    @(negedge clk);
    set_in(1'b0, REG_ZERO, 32'h0, 1'b0, REG_ZERO, 5'd4, 5'd9);
    #1;
    chk("swap_busy4", bus_b.busy1, 1);
    chk("swap_busy9", bus_b.busy2, 0);
    chk("swap_value9", bus_b.value2, 32'h77);
    chk("swap_count", bus_b.pending_count, 1);
    chk("swap_n_count", bus_n.pending_count, 1);

    // Writing a non-pending register leaves the count alone
    @(negedge clk);
    set_in(1'b1, 5'd12, 32'h55, 1'b0, REG_ZERO, 5'd12, REG_ZERO);
    @(posedge clk); #1;
    chk("nonpend_count", bus_b.pending_count, 1);

    // Retire x4
    @(negedge clk);
    set_in(1'b1, 5'd4, 32'h44, 1'b0, REG_ZERO, 5'd4, REG_ZERO);
    @(posedge clk); #1;
    chk("wb4_count", bus_b.pending_count, 0);

    // Fill the scoreboard
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      set_in(1'b0, REG_ZERO, 32'h0, 1'b1, reg_addr_t'(i), reg_addr_t'(i), REG_ZERO);
      @(posedge clk); #1;
      chk("fill_count", bus_b.pending_count, i);
    end
    @(negedge clk);
    set_in(1'b0, REG_ZERO, 32'h0, 1'b1, 5'd17, 5'd17, 5'd31);
    @(posedge clk); #1;
    chk("full_rereserve_count", bus_b.pending_count, 31);
    chk("full_busy2", bus_b.busy2, 1);

    // Async reset mid-cycle with write and reserve in flight
    @(negedge clk);
    set_in(1'b1, 5'd6, 32'hCAFE, 1'b1, 5'd6, 5'd5, 5'd7);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_count", bus_b.pending_count, 0);
    chk("arst_value1", bus_b.value1, 0);
    chk("arst_busy1", bus_b.busy1, 0);
    chk("arst_n_value2", bus_n.value2, 0);
    @(posedge clk); #1;
    set_in(1'b0, REG_ZERO, 32'h0, 1'b0, REG_ZERO, 5'd6, 5'd6);
    #1;
    chk("arst_drop_value6", bus_b.value1, 0);
    chk("arst_drop_busy6", bus_b.busy1, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_count", bus_b.pending_count, 0);
    chk("post_rst_value6", bus_b.value2, 0);
    chk("post_rst_n_value6", bus_n.value1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
